// File: rtl/hex_keypad_scanner.sv
// Hex keypad scanner: drives one column of a 4x4 matrix keypad at a time,
// debounces a press on the detected row, emits a one-cycle event with the
// key's hex code, and shifts accepted codes into a 16-bit display word.
module hex_keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  KP_ROW,
    output logic [3:0]  KP_COL,
    output logic        KEY_VALID,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_HELD,
    output logic [15:0] DATA
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam int DW = $clog2(DEBOUNCE_N + 1);
    localparam logic [DW-1:0] DB_TGT = DW'(DEBOUNCE_N);
    localparam logic [DW-1:0] DB_ONE = DW'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    logic          rst_meta;
    logic          rst_sync;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [PW-1:0] period;
    logic [1:0]    col;
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_n;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_cnt_n;
    logic [DW-1:0] db_next;
    state_t        state;
    state_t        state_n;
    logic          sample;
    logic          any_low;
    logic          row_hit;
    logic          accept;
    logic          release_key;
    logic          col_adv;
    logic [3:0]    accept_code;

    // Saturating increment: the debounce count never wraps past the target.
    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        if (v >= DB_TGT) return DB_TGT;
        return v + DB_ONE;
    endfunction

    // Lowest-index active-low row wins when several rows are pressed.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0]) return 2'd0;
        if (!r[1]) return 2'd1;
        if (!r[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Physical keypad layout: row r, column c to hex code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            4'b11_11: return 4'hD;
        endcase
    endfunction

    // Reset asserts immediately but releases in step with CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Two-flop synchronizer for the asynchronous keypad rows (idle high).
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= KP_ROW;
            row_sync <= row_meta;
        end
    end

    // Scan period counter and column pointer; column moves only on a sample.
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            period <= '0;
            col    <= 2'd0;
        end else begin
            if (period == PMAX) period <= '0;
            else                period <= period + PW'(1);
            if (col_adv) col <= col + 2'd1;
        end
    end

    assign sample  = (period == PMAX);
    assign any_low = ~&row_sync;
    assign row_hit = ~row_sync[row_idx];
    assign db_next = sat_inc(db_cnt);

    // FSM state register together with the latched row and debounce count.
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            db_cnt  <= '0;
        end else begin
            state   <= state_n;
            row_idx <= row_idx_n;
            db_cnt  <= db_cnt_n;
        end
    end

    // Next-state logic; all decisions are taken only at the sample point.
    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        db_cnt_n    = db_cnt;
        accept      = 1'b0;
        release_key = 1'b0;
        col_adv     = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_idx_n = lowest_low(row_sync);
                        db_cnt_n  = DB_ONE;
                        if (DB_ONE >= DB_TGT) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end else begin
                            state_n = PRESS_DB;
                        end
                    end else begin
                        col_adv = 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (row_hit) begin
                        db_cnt_n = db_next;
                        if (db_next >= DB_TGT) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                        col_adv = 1'b1;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        db_cnt_n = DB_ONE;
                        if (DB_ONE >= DB_TGT) begin
                            state_n     = SCAN;
                            release_key = 1'b1;
                            col_adv     = 1'b1;
                        end else begin
                            state_n = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (!row_hit) begin
                        db_cnt_n = db_next;
                        if (db_next >= DB_TGT) begin
                            state_n     = SCAN;
                            release_key = 1'b1;
                            col_adv     = 1'b1;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Output decode: one-hot-low column drive and the code of the key being accepted.
    always_comb begin
        KP_COL      = ~(4'b0001 << col);
        accept_code = key_map(row_idx_n, col);
    end

    // Registered key event, held flag and scrolling display word.
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            KEY_VALID <= 1'b0;
            KEY_CODE  <= 4'h0;
            KEY_HELD  <= 1'b0;
            DATA      <= 16'h0000;
        end else begin
            KEY_VALID <= accept;
            if (accept) begin
                KEY_CODE <= accept_code;
                DATA     <= {DATA[11:0], accept_code};
                KEY_HELD <= 1'b1;
            end else if (release_key) begin
                KEY_HELD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a physical keypad model (pressed-key matrix
// shorted onto the driven column) and an event-level reference of the
// expected codes and display word.
module tb_hex_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  kp_row;
    logic [3:0]  kp_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] data;

    logic [3:0]  pressed [4];
    logic [3:0]  row_model;
    logic        row_ovr_en = 1'b0;
    logic [3:0]  row_ovr = 4'hF;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc;
    int          pulses = 0;
    logic [15:0] exp_data = 16'h0000;

    hex_keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEBOUNCE_N(DEBOUNCE_N)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .KP_ROW   (kp_row),
        .KP_COL   (kp_col),
        .KEY_VALID(key_valid),
        .KEY_CODE (key_code),
        .KEY_HELD (key_held),
        .DATA     (data)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++) row_model[r] = ~|(pressed[r] & ~kp_col);
    end
    assign kp_row = row_ovr_en ? row_ovr : row_model;

    // Cycles since reset release; used to align stimulus to scan periods.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Count every key event pulse.
    always @(negedge clk) begin
        if (key_valid) pulses++;
    end

    function automatic logic [3:0] ref_code(input int r, input int c);
        logic [15:0] row_codes;
        case (r)
            0:       row_codes = 16'h123A;
            1:       row_codes = 16'h456B;
            2:       row_codes = 16'h789C;
            default: row_codes = 16'hE0FD;
        endcase
        return row_codes[15-4*c -: 4];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step(1);
    endtask

    // Internal reset releases two cycles after RST_N; sample edges fall on cyc%4==2.
    task automatic align();
        while (cyc % SCAN_DIV != 2) step(1);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic do_reset();
        clear_keys();
        exp_data = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(output bit ok);
        for (int i = 0; i < 200 && !key_valid; i++) step(1);
        ok = key_valid;
    endtask

    task automatic wait_release(output bit ok);
        for (int i = 0; i < 200 && key_held; i++) step(1);
        ok = !key_held;
    endtask

    task automatic press_release(input int r, input int c, input int hold);
        int         p0;
        bit         ok;
        logic [3:0] code;
        p0   = pulses;
        code = ref_code(r, c);
        pressed[r][c] = 1'b1;
        wait_pulse(ok);
        check_eq("press_seen", 32'(ok), 32'd1);
        exp_data = {exp_data[11:0], code};
        check_eq("key_code", 32'(key_code), 32'(code));
        check_eq("data", 32'(data), 32'(exp_data));
        check_eq("held_on", 32'(key_held), 32'd1);
        step(1);
        check_eq("pulse_width", 32'(key_valid), 32'd0);
        step(hold * SCAN_DIV);
        check_eq("one_pulse", 32'(pulses - p0), 32'd1);
        pressed[r][c] = 1'b0;
        wait_release(ok);
        check_eq("release_seen", 32'(ok), 32'd1);
        step(8);
        check_eq("no_extra_pulse", 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        bit ok;
        bit bounce_rel [5];
        clear_keys();

        // Reset held while rows toggle.
        rst_n = 1'b0;
        row_ovr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            row_ovr = 4'($urandom);
            @(negedge clk);
        end
        check_eq("rst_col", 32'(kp_col), 32'hE);
        check_eq("rst_data", 32'(data), 32'h0);
        check_eq("rst_valid", 32'(key_valid), 32'h0);
        check_eq("rst_held", 32'(key_held), 32'h0);
        check_eq("rst_code", 32'(key_code), 32'h0);
        row_ovr_en = 1'b0;
        rst_n = 1'b1;
        step_to(5);  check_eq("scan_c0", 32'(kp_col), 32'hE);
        step_to(6);  check_eq("scan_c1", 32'(kp_col), 32'hD);
        step_to(9);  check_eq("scan_c1_hold", 32'(kp_col), 32'hD);
        step_to(10); check_eq("scan_c2", 32'(kp_col), 32'hB);
        step_to(14); check_eq("scan_c3", 32'(kp_col), 32'h7);
        step_to(18); check_eq("scan_wrap", 32'(kp_col), 32'hE);

        // Single press of row1/col2 and timed release.
        do_reset();
        p0 = pulses;
        pressed[1][2] = 1'b1;
        wait_pulse(ok);
        check_eq("single_seen", 32'(ok), 32'd1);
        check_eq("single_code", 32'(key_code), 32'h6);
        check_eq("single_data", 32'(data), 32'h0006);
        check_eq("single_held", 32'(key_held), 32'd1);
        step(1);
        check_eq("single_width", 32'(key_valid), 32'd0);
        step(12);
        check_eq("single_count", 32'(pulses - p0), 32'd1);
        align();
        pressed[1][2] = 1'b0;
        step(8);
        check_eq("single_held_2rel", 32'(key_held), 32'd1);
        step(4);
        check_eq("single_released", 32'(key_held), 32'd0);
        check_eq("single_resume_c3", 32'(kp_col), 32'h7);

        // Sequence C, A, F, E, 1.
        do_reset();
        p0 = pulses;
        press_release(2, 3, 1);
        press_release(0, 3, 2);
        press_release(3, 2, 0);
        press_release(3, 0, 3);
        press_release(0, 0, 1);
        check_eq("seq_data", 32'(data), 32'hAFE1);
        check_eq("seq_pulses", 32'(pulses - p0), 32'd5);

        // Press bounce then release bounce on row1/col1.
        do_reset();
        exp_data = 16'h0000;
        align();
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            pressed[1][1] = (i % 2 == 0);
            step(SCAN_DIV);
        end
        check_eq("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        pressed[1][1] = 1'b1;
        wait_pulse(ok);
        check_eq("bounce_seen", 32'(ok), 32'd1);
        check_eq("bounce_code", 32'(key_code), 32'h5);
        exp_data = {exp_data[11:0], 4'h5};
        check_eq("bounce_data", 32'(data), 32'(exp_data));
        align();
        bounce_rel = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            pressed[1][1] = bounce_rel[i];
            step(SCAN_DIV);
            if (i == 3) check_eq("rel_bounce_held", 32'(key_held), 32'd1);
        end
        check_eq("rel_bounce_done", 32'(key_held), 32'd0);
        check_eq("rel_bounce_pulses", 32'(pulses - p0), 32'd1);

        // Two rows on column 1, then another column's key while held.
        p0 = pulses;
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        wait_pulse(ok);
        check_eq("multi_seen", 32'(ok), 32'd1);
        check_eq("multi_code", 32'(key_code), 32'h2);
        exp_data = {exp_data[11:0], 4'h2};
        check_eq("multi_data", 32'(data), 32'(exp_data));
        pressed[1][3] = 1'b1;
        step(16);
        check_eq("rollover_pulses", 32'(pulses - p0), 32'd1);
        check_eq("rollover_held", 32'(key_held), 32'd1);
        clear_keys();
        wait_release(ok);
        check_eq("multi_release", 32'(ok), 32'd1);
        step(32);
        check_eq("multi_final_pulses", 32'(pulses - p0), 32'd1);

        // Reset during press debounce after two samples.
        do_reset();
        p0 = pulses;
        pressed[0][0] = 1'b1;
        step_to(11);
        rst_n = 1'b0;
        #1;
        check_eq("mid_col", 32'(kp_col), 32'hE);
        check_eq("mid_valid", 32'(key_valid), 32'd0);
        check_eq("mid_held", 32'(key_held), 32'd0);
        check_eq("mid_code", 32'(key_code), 32'd0);
        check_eq("mid_data", 32'(data), 32'h0);
        step(20);
        pressed[0][0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(40);
        check_eq("mid_after_data", 32'(data), 32'h0);
        check_eq("mid_no_pulse", 32'(pulses - p0), 32'd0);

        // Randomized key sequence against the shift-register reference.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end
        check_eq("rand_data", 32'(data), 32'(exp_data));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Input-side counterpart of the hex display driver: scans a 4x4 hex matrix keypad and debounces presses. Each accepted key press produces a one-cycle event with its 4-bit hex code and shifts the code into a 16-bit value. The 16-bit DATA output connects directly to the hex display driver's data input, so typed digits scroll in from the right.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before moving on or re-sampling; minimum 4
DEBOUNCE_N, 8, consecutive agreeing row samples needed to accept a press or a release; minimum 1

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
KP_ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK
KP_COL  output  4  keypad column drive, active-low, exactly one bit low at all times
KEY_VALID  output  1  one-cycle pulse when a press is accepted
KEY_CODE  output  4  hex code of last accepted key; stable until next accept
KEY_HELD  output  1  high from accept until release is accepted
DATA  output  16  shift register of the last four accepted codes, newest in [3:0]

Behaviour:
- Reset (async assert, sync deassert internal): KP_COL=4'b1110 (column 0), KEY_VALID=0, KEY_CODE=0, KEY_HELD=0, DATA=16'h0000, state=SCAN, all counters 0.
- KP_ROW passes through a 2-FF synchronizer before use. Do not sample KP_ROW before the synchronizer.
- A period counter counts 0..SCAN_DIV-1 and wraps.
- Sample point: the cycle where the period counter equals SCAN_DIV-1. Settling plus synchronizer latency fits inside the period because SCAN_DIV is at least 4.
- Row priority: if several synced rows are low, the lowest index wins.
- Key map, row r / col c to code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- FSM states and transitions:
  - SCAN: at each sample point, if any row is low, latch row index R and stay on the current column. Clear the debounce count, set it to 1, go to PRESS_DB. Otherwise advance the column 0->1->2->3->0.
  - PRESS_DB: column held. At each sample point, if row R is low, count++. When count reaches DEBOUNCE_N, go to HELD and accept. If row R is high, go to SCAN and advance to the next column.
  - Accept: on the same cycle as the PRESS_DB->HELD transition:
    - KEY_VALID=1 for exactly that cycle.
    - KEY_CODE=map(R,col).
    - DATA <= {DATA[11:0], code}.
    - KEY_HELD <= 1.
  - HELD: column held. At a sample point where row R is high, set count=1 and go to REL_DB.
  - REL_DB: at each sample point, if row R is high, count++. When count reaches DEBOUNCE_N, KEY_HELD <= 0 and go to SCAN, advancing the column. If row R is low, return to HELD with no new KEY_VALID.
- Other keys pressed while in PRESS_DB, HELD or REL_DB are ignored (no rollover).
- With DEBOUNCE_N=1, an accept occurs on the first sample point that sees the press (SCAN goes straight to HELD).
- Latency: the first accept follows the press by DEBOUNCE_N-1 sample periods after the detecting sample point, plus up to 4*SCAN_DIV+2 cycles of scan and synchronizer delay.
- DATA wraps naturally: the fifth key discards the oldest nibble.
- Reset asserted mid-debounce or mid-hold forces the reset values immediately. No KEY_VALID is produced for the interrupted press.
- The debounce counter is ceil(log2(DEBOUNCE_N+1)) bits and saturates. It must not wrap.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_N=3.
- Reset: hold RST_N=0 and toggle KP_ROW. Expect KP_COL=1110, DATA=0000, KEY_VALID=0. Release reset: KP_COL steps 1110->1101->1011->0111 every 4 cycles and wraps.
- Single press: model key row1/col2 (row1 low while col2 driven) and hold it. Expect exactly one KEY_VALID pulse, KEY_CODE=6, DATA=0006, KEY_HELD=1. Release: KEY_HELD falls after 3 high samples and scanning resumes at col3.
- Sequence: press and release C, A, F, E, then 1. DATA goes 000C, 00CA, 0CAF, CAFE, AFE1. Expect 5 KEY_VALID pulses total.
- Bounce: row toggles low/high on alternate sample points for 10 samples, then stays low. Expect no pulse during bouncing and one pulse after 3 stable low samples. Release bounce (high, low, high, high, high) produces no second pulse.
- Simultaneous keys: rows 0 and 2 low on col 1. Expect code 2 (row 0 wins) and one pulse. Pressing another column's key while HELD produces no pulse.
- Reset mid-debounce: assert RST_N=0 while in PRESS_DB after 2 samples. Expect all outputs at reset values and no KEY_VALID, and DATA stays 0000.
